grade_accumulator: RTL and testbench
====================================

GRADE_ACCUMULATOR -- requirements
Module: grade_accumulator

Interface
REQ-001 Parameter NGRADES, default 4: number of grades averaged per student, at least 1.
REQ-002 Parameter GRADE_BITS, default 4: width of grade_in.
REQ-003 Parameter MAX_GRADE, default 10: highest legal grade.
REQ-004 Parameter PASS_MIN, default 7: lowest average shown as approved.
REQ-005 Parameter FINAL_MIN, default 4: lowest average shown as final-exam.
REQ-006 Port clk_2, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-007 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-008 Port grade_in, input, GRADE_BITS: grade value, sampled on an accepted enter.
REQ-009 Port enter, input, 1 bit: level from a push-button; the block SHALL detect its rising edge internally.
REQ-010 Port clear, input, 1 bit: synchronous abort and restart.
REQ-011 Port mode, input, 1 bit: SEG format; 0 shows the average digit, 1 shows a status letter.
REQ-012 Port SEG, output, 8 bits: seven-segment display; SEG[0..6] drive segments a..g and SEG[7] drives dp; 1 lights a segment.
REQ-013 Port count, output, $clog2(NGRADES+1) bits: number of grades accepted so far.
REQ-014 Port avg, output, $clog2(MAX_GRADE+1) bits: the computed average.
REQ-015 Port valid, output, 1 bit: high while avg is final.
REQ-016 Port busy, output, 1 bit: high during division.
REQ-017 Port err, output, 1 bit: sticky flag for an out-of-range grade.

Function
REQ-018 The state machine SHALL have three states: COLLECT, DIVIDE and SHOW.
REQ-019 The edge detector SHALL register enter once per cycle; an edge is registered enter = 0 while enter = 1, so one press yields one edge however long enter is held.
REQ-020 In COLLECT, an edge with grade_in <= MAX_GRADE SHALL add grade_in to sum, increment count and clear err.
REQ-021 Sum width SHALL be $clog2(MAX_GRADE*NGRADES+1) bits, with no overflow possible.
REQ-022 In COLLECT, an edge with grade_in > MAX_GRADE SHALL set err and leave sum and count unchanged.
REQ-023 The edge that makes count equal NGRADES SHALL move the machine to DIVIDE on the next cycle, with rem = sum and quot = 0.
REQ-024 In DIVIDE, each cycle with rem >= NGRADES SHALL apply rem -= NGRADES and quot += 1.
REQ-025 The first cycle in DIVIDE with rem < NGRADES SHALL load avg = quot and move to SHOW.
REQ-026 The average is floor(sum/NGRADES); DIVIDE SHALL last floor(sum/NGRADES)+1 cycles.
REQ-027 busy SHALL be 1 exactly while in DIVIDE.
REQ-028 valid SHALL be 1 exactly while in SHOW.
REQ-029 In SHOW, an enter edge SHALL return the machine to COLLECT with sum = 0, count = 0 and valid = 0.
REQ-030 Enter edges in DIVIDE SHALL be ignored.
REQ-031 clear = 1 SHALL force COLLECT on the next edge from any state, with sum = 0, count = 0, avg = 0 and err = 0.
REQ-032 When clear and an enter edge occur in the same cycle, clear SHALL win and the grade SHALL be discarded.
REQ-033 In COLLECT and DIVIDE, SEG SHALL be 8'h00.
REQ-034 In SHOW with mode = 0 and avg <= 9, SEG SHALL show the digit: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F (hex).
REQ-035 In SHOW with mode = 0 and avg >= 10, SEG SHALL show the digit pattern of avg-10 with SEG[7] = 1.
REQ-036 In SHOW with mode = 1, SEG SHALL be 8'h77 ('A') if avg >= PASS_MIN, 8'h79 ('E') if FINAL_MIN <= avg < PASS_MIN, and 8'h50 ('r') otherwise.
REQ-037 SEG SHALL be a combinational function of state, avg and mode, so a change of mode shows on SEG in the same cycle.

Reset
REQ-038 While reset = 1, asynchronously and at any time including mid-DIVIDE, the block SHALL force state COLLECT with sum, rem, quot, avg and count at 0, valid, busy and err at 0, registered enter at 1 and SEG at 8'h00.
REQ-039 On reset release, a button still held SHALL NOT register as an edge.

Verification
REQ-040 Pulse reset mid-DIVIDE -> SEG=00, count=0, busy=0 and valid=0 immediately, without waiting for a clock edge.
REQ-041 Enter grades 8, 7, 9, 6 with defaults -> busy=1 for 8 cycles, then valid=1, avg=7; SEG=07 with mode=0 and SEG=77 with mode=1.
REQ-042 Enter grades 5, 4, 3, 4 -> avg=4, SEG=79 with mode=1; grades 1, 2, 0, 3 -> avg=1, SEG=50 with mode=1.
REQ-043 Enter grade 12, then 0 -> after 12: err=1, count=0; after 0: err=0, count=1.
REQ-044 Enter grades 10, 10, 10, 10 -> avg=10, SEG=BF with mode=0 and SEG=77 with mode=1.
REQ-045 Hold enter high for 5 cycles -> count rises by exactly 1; assert clear in the same cycle as an enter edge -> count=0, grade discarded.

Source files
------------

// File: rtl/grade_accumulator_if.sv
// Signal bundle for grade_accumulator: button/grade inputs and display/status outputs.
// Signal names match the block's original port names.
interface grade_accumulator_if #(
   parameter int NGRADES    = 4,
   parameter int GRADE_BITS = 4,
   parameter int MAX_GRADE  = 10
);
   localparam int CNT_W = $clog2(NGRADES + 1);
   localparam int AVG_W = $clog2(MAX_GRADE + 1);

   logic [GRADE_BITS-1:0] grade_in;
   logic                  enter;
   logic                  clear;
   logic                  mode;
   logic [7:0]            SEG;
   logic [CNT_W-1:0]      count;
   logic [AVG_W-1:0]      avg;
   logic                  valid;
   logic                  busy;
   logic                  err;

   modport master (
      output grade_in, enter, clear, mode,
      input  SEG, count, avg, valid, busy, err
   );

   modport slave (
      input  grade_in, enter, clear, mode,
      output SEG, count, avg, valid, busy, err
   );
endinterface

// File: rtl/grade_accumulator.sv
// Collects NGRADES button-entered grades, divides by repeated subtraction and
// shows the average (digit or pass/final/fail letter) on a seven-segment display.
module grade_accumulator #(
   parameter int NGRADES    = 4,
   parameter int GRADE_BITS = 4,
   parameter int MAX_GRADE  = 10,
   parameter int PASS_MIN   = 7,
   parameter int FINAL_MIN  = 4
) (
   input logic clk_2,
   input logic reset,
   grade_accumulator_if.slave bus
);
   localparam int SUM_W = $clog2(MAX_GRADE * NGRADES + 1);
   localparam int CNT_W = $clog2(NGRADES + 1);
   localparam int AVG_W = $clog2(MAX_GRADE + 1);
   localparam int unsigned MAXG  = MAX_GRADE;
   localparam int unsigned PASSU = PASS_MIN;
   localparam int unsigned FINLU = FINAL_MIN;

   typedef enum logic [1:0] {COLLECT, DIVIDE, SHOW} state_t;

   state_t             state, state_n;
   logic               enter_q;
   logic [SUM_W-1:0]   sum, sum_n;
   logic [SUM_W-1:0]   rem, rem_n;
   logic [AVG_W-1:0]   quot, quot_n;
   logic [AVG_W-1:0]   avg_r, avg_n;
   logic [CNT_W-1:0]   count_r, count_n;
   logic               err_r, err_n;
   logic               enter_edge;
   logic               grade_ok;
   logic [7:0]         seg;

   // enter_q resets high so a button held through reset release is not an edge
   assign enter_edge = bus.enter & ~enter_q;
   assign grade_ok   = 32'(bus.grade_in) <= MAXG;

   always_ff @(posedge clk_2 or posedge reset) begin
      if (reset) begin
         state   <= COLLECT;
         enter_q <= 1'b1;
         sum     <= '0;
         rem     <= '0;
         quot    <= '0;
         avg_r   <= '0;
         count_r <= '0;
         err_r   <= 1'b0;
      end else begin
         state   <= state_n;
         enter_q <= bus.enter;
         sum     <= sum_n;
         rem     <= rem_n;
         quot    <= quot_n;
         avg_r   <= avg_n;
         count_r <= count_n;
         err_r   <= err_n;
      end
   end

   always_comb begin
      state_n = state;
      sum_n   = sum;
      rem_n   = rem;
      quot_n  = quot;
      avg_n   = avg_r;
      count_n = count_r;
      err_n   = err_r;
      if (bus.clear) begin
         state_n = COLLECT;
         sum_n   = '0;
         rem_n   = '0;
         quot_n  = '0;
         avg_n   = '0;
         count_n = '0;
         err_n   = 1'b0;
      end else begin
         case (state)
            COLLECT: begin
               if (enter_edge) begin
                  if (grade_ok) begin
                     sum_n   = sum + SUM_W'(bus.grade_in);
                     count_n = count_r + CNT_W'(1);
                     err_n   = 1'b0;
                     if (count_n == CNT_W'(NGRADES)) begin
                        state_n = DIVIDE;
                        rem_n   = sum_n;
                        quot_n  = '0;
                     end
                  end else begin
                     err_n = 1'b1;
                  end
               end
            end
            DIVIDE: begin
               if (rem >= SUM_W'(NGRADES)) begin
                  rem_n  = rem - SUM_W'(NGRADES);
                  quot_n = quot + AVG_W'(1);
               end else begin
                  avg_n   = quot;
                  state_n = SHOW;
               end
            end
            SHOW: begin
               if (enter_edge) begin
                  state_n = COLLECT;
                  sum_n   = '0;
                  count_n = '0;
               end
            end
            default: state_n = COLLECT;
         endcase
      end
   end

   function automatic logic [7:0] digit_seg(input int unsigned d);
      case (d)
         0:       digit_seg = 8'h3F;
         1:       digit_seg = 8'h06;
         2:       digit_seg = 8'h5B;
         3:       digit_seg = 8'h4F;
         4:       digit_seg = 8'h66;
         5:       digit_seg = 8'h6D;
         6:       digit_seg = 8'h7D;
         7:       digit_seg = 8'h07;
         8:       digit_seg = 8'h7F;
         9:       digit_seg = 8'h6F;
         default: digit_seg = 8'h00;
      endcase
   endfunction

   // Display is purely combinational so a mode change shows in the same cycle
   always_comb begin
      int unsigned a;
      a   = 32'(avg_r);
      seg = 8'h00;
      if (state == SHOW) begin
         if (!bus.mode) begin
            if (a <= 9) seg = digit_seg(a);
            else        seg = digit_seg(a - 10) | 8'h80;
         end else begin
            if (a >= PASSU)      seg = 8'h77;
            else if (a >= FINLU) seg = 8'h79;
            else                 seg = 8'h50;
         end
      end
   end

   assign bus.SEG   = seg;
   assign bus.count = count_r;
   assign bus.avg   = avg_r;
   assign bus.valid = (state == SHOW);
   assign bus.busy  = (state == DIVIDE);
   assign bus.err   = err_r;
endmodule

// File: tb/tb_grade_accumulator.sv
// Directed-vector bench for grade_accumulator: stimulus queues expected averages,
// a negedge monitor compares them when valid rises; flag/count checks run inline.
module tb_grade_accumulator;
   logic clk_2 = 1'b0;
   logic reset = 1'b0;
   always #5 clk_2 = ~clk_2;

   grade_accumulator_if #(.NGRADES(4), .GRADE_BITS(4), .MAX_GRADE(10)) bus ();

   grade_accumulator #(
      .NGRADES(4), .GRADE_BITS(4), .MAX_GRADE(10), .PASS_MIN(7), .FINAL_MIN(4)
   ) dut (
      .clk_2(clk_2),
      .reset(reset),
      .bus  (bus)
   );

   typedef struct {
      logic [3:0] avg;
      int         cyc;
      logic [7:0] seg0;
      logic [7:0] seg1;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, got, want);
      end
   endtask

   // Monitor: pops one expected result each time valid rises
   exp_t cur;
   bit   have_cur   = 1'b0;
   bit   prev_valid = 1'b0;
   int   busy_cnt   = 0;

   always @(negedge clk_2) begin
      if (reset) begin
         busy_cnt   = 0;
         prev_valid = 1'b0;
         have_cur   = 1'b0;
      end else begin
         if (bus.busy) busy_cnt++;
         if (bus.valid && !prev_valid) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_result: valid rose with empty scoreboard, avg %0d", bus.avg);
               have_cur = 1'b0;
            end else begin
               cur      = exp_q.pop_front();
               have_cur = 1'b1;
               check("avg", 32'(bus.avg), 32'(cur.avg));
               check("busy_cycles", busy_cnt, cur.cyc);
            end
            busy_cnt = 0;
         end
         if (bus.valid && have_cur)
            check(bus.mode ? "seg_mode1" : "seg_mode0", 32'(bus.SEG),
                  32'(bus.mode ? cur.seg1 : cur.seg0));
         if (!bus.valid) have_cur = 1'b0;
         prev_valid = bus.valid;
      end
   end

   task automatic press(input logic [3:0] g, input int hold);
      @(posedge clk_2); #1;
      bus.grade_in = g;
      bus.enter    = 1'b1;
      repeat (hold) @(posedge clk_2);
      #1 bus.enter = 1'b0;
      @(posedge clk_2); #1;
   endtask

   task automatic wait_valid(input string name);
      int k = 0;
      while (!bus.valid && k < 100) begin
         @(negedge clk_2);
         k++;
      end
      check({name, "_valid_timeout"}, 32'(bus.valid), 32'd1);
   endtask

   task automatic show_both_modes();
      @(posedge clk_2); #1 bus.mode = 1'b1;
      repeat (2) @(posedge clk_2);
      #1 bus.mode = 1'b0;
      @(posedge clk_2); #1;
   endtask

   task automatic run_set(input string name, input logic [3:0] g0, input logic [3:0] g1,
                          input logic [3:0] g2, input logic [3:0] g3, input exp_t e);
      exp_q.push_back(e);
      press(g0, 1);
      press(g1, 1);
      press(g2, 1);
      press(g3, 1);
      wait_valid(name);
      show_both_modes();
      press(4'd0, 1);
      check({name, "_restart_count"}, 32'(bus.count), 32'd0);
      check({name, "_restart_valid"}, 32'(bus.valid), 32'd0);
   endtask

   initial begin
      bus.grade_in = '0;
      bus.enter    = 1'b1;
      bus.clear    = 1'b0;
      bus.mode     = 1'b0;
      #1 reset = 1'b1;
      #11;
      check("rst_seg",   32'(bus.SEG),   32'h00);
      check("rst_count", 32'(bus.count), 32'd0);
      check("rst_valid", 32'(bus.valid), 32'd0);
      check("rst_busy",  32'(bus.busy),  32'd0);
      check("rst_err",   32'(bus.err),   32'd0);
      check("rst_avg",   32'(bus.avg),   32'd0);

      // button held across reset release must not count
      @(posedge clk_2); #1 reset = 1'b0;
      repeat (3) @(posedge clk_2);
      #1 check("held_release_count", 32'(bus.count), 32'd0);
      bus.enter = 1'b0;
      @(posedge clk_2); #1;

      run_set("s8796", 4'd8, 4'd7, 4'd9, 4'd6, '{avg: 4'd7, cyc: 8,  seg0: 8'h07, seg1: 8'h77});
      run_set("s5434", 4'd5, 4'd4, 4'd3, 4'd4, '{avg: 4'd4, cyc: 5,  seg0: 8'h66, seg1: 8'h79});
      run_set("s1203", 4'd1, 4'd2, 4'd0, 4'd3, '{avg: 4'd1, cyc: 2,  seg0: 8'h06, seg1: 8'h50});
      run_set("s0000", 4'd0, 4'd0, 4'd0, 4'd0, '{avg: 4'd0, cyc: 1,  seg0: 8'h3F, seg1: 8'h50});
      run_set("s4443", 4'd4, 4'd4, 4'd4, 4'd3, '{avg: 4'd3, cyc: 4,  seg0: 8'h4F, seg1: 8'h50});

      press(4'd12, 1);
      check("bad12_err",   32'(bus.err),   32'd1);
      check("bad12_count", 32'(bus.count), 32'd0);
      press(4'd0, 1);
      check("good0_err",   32'(bus.err),   32'd0);
      check("good0_count", 32'(bus.count), 32'd1);

      press(4'd3, 5);
      check("held5_count", 32'(bus.count), 32'd2);

      press(4'd15, 1);
      check("bad15_err", 32'(bus.err), 32'd1);
      @(posedge clk_2); #1;
      bus.grade_in = 4'd5;
      bus.enter    = 1'b1;
      bus.clear    = 1'b1;
      @(posedge clk_2); #1;
      check("clear_edge_count", 32'(bus.count), 32'd0);
      check("clear_edge_err",   32'(bus.err),   32'd0);
      bus.clear = 1'b0;
      bus.enter = 1'b0;
      @(posedge clk_2); #1;

      // all tens, with a press landing mid-divide that must be ignored
      exp_q.push_back('{avg: 4'd10, cyc: 11, seg0: 8'hBF, seg1: 8'h77});
      repeat (4) press(4'd10, 1);
      press(4'd1, 1);
      wait_valid("s10");
      check("s10_count_after_ignored", 32'(bus.count), 32'd4);
      show_both_modes();
      bus.clear = 1'b1;
      @(posedge clk_2); #1 bus.clear = 1'b0;
      check("show_clear_avg",   32'(bus.avg),   32'd0);
      check("show_clear_valid", 32'(bus.valid), 32'd0);
      check("show_clear_seg",   32'(bus.SEG),   32'h00);
      check("show_clear_count", 32'(bus.count), 32'd0);

      // asynchronous reset in the middle of a division
      repeat (4) press(4'd10, 1);
      @(posedge clk_2); #1;
      check("pre_reset_busy", 32'(bus.busy), 32'd1);
      #1 reset = 1'b1;
      #1;
      check("async_rst_seg",   32'(bus.SEG),   32'h00);
      check("async_rst_count", 32'(bus.count), 32'd0);
      check("async_rst_busy",  32'(bus.busy),  32'd0);
      check("async_rst_valid", 32'(bus.valid), 32'd0);
      @(posedge clk_2); #1 reset = 1'b0;
      repeat (3) @(posedge clk_2);
      #1;
      check("post_rst_count", 32'(bus.count), 32'd0);
      check("post_rst_valid", 32'(bus.valid), 32'd0);

      check("scoreboard_drained", exp_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
